// File: rtl/onehot_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | onehot_seq_pkg : shared types and helpers for onehot_sequencer         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package onehot_seq_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic MODE_DECODE = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Wide enough for any SEL_W up to 8; callers truncate to their own OUT_W.
   localparam int ONEHOT_MAX_W = 256;

   function automatic logic [ONEHOT_MAX_W-1:0] onehot_of(input logic [7:0] sel);
      onehot_of      = '0;
      onehot_of[sel] = 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_sequencer_dwell_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dwell_timer : loadable down-counter, loads DWELL-1, flags zero         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module dwell_timer #(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CNT_W'(DWELL - 1);
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/onehot_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | onehot_sequencer : registered one-hot decoder with dwell and scan.    |
// | Scan walk is built only when ONEHOT_SEQ_SCAN_EN is defined.  Rev 1.0  |
// +-----------------------------------------------------------------------+
module onehot_sequencer
   import onehot_seq_pkg::*;
#(
   parameter int SEL_W = 2,
   parameter int DWELL = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_mode,
   input  logic                  abort,
   output logic [2**SEL_W-1:0]   out_onehot,
   output logic [SEL_W-1:0]      out_index,
   output logic                  out_valid
);

   localparam int OUT_W = 2**SEL_W;

   state_e             state_q, state_d;
   logic [OUT_W-1:0]   onehot_q, onehot_d;
   logic [SEL_W-1:0]   index_q, index_d;
   logic               valid_q, valid_d;
   logic               tmr_load, tmr_dec, tmr_zero;
`ifdef ONEHOT_SEQ_SCAN_EN
   logic [SEL_W-1:0]   steps_q, steps_d;
`else
   logic               unused_mode;
   assign unused_mode = in_mode;
`endif

   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .dec   (tmr_dec),
      .zero  (tmr_zero)
   );

   assign in_ready = (state_q == IDLE) && !abort;

   always_comb begin
      state_d  = state_q;
      onehot_d = onehot_q;
      index_d  = index_q;
      valid_d  = valid_q;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
`ifdef ONEHOT_SEQ_SCAN_EN
      steps_d  = steps_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               state_d  = RUN;
               onehot_d = OUT_W'(onehot_of(8'(in_sel)));
               index_d  = in_sel;
               valid_d  = 1'b1;
               tmr_load = 1'b1;
`ifdef ONEHOT_SEQ_SCAN_EN
               steps_d  = (in_mode == MODE_SCAN) ? SEL_W'(OUT_W - 1) : '0;
`endif
            end
         end
         RUN: begin
            if (abort) begin
               state_d  = IDLE;
               onehot_d = '0;
               valid_d  = 1'b0;
            end else if (!tmr_zero) begin
               tmr_dec = 1'b1;
`ifdef ONEHOT_SEQ_SCAN_EN
            end else if (steps_q != '0) begin
               // Advance to the next line; index and rotation both wrap naturally.
               onehot_d = {onehot_q[OUT_W-2:0], onehot_q[OUT_W-1]};
               index_d  = index_q + SEL_W'(1);
               tmr_load = 1'b1;
               steps_d  = steps_q - SEL_W'(1);
`endif
            end else begin
               state_d  = IDLE;
               onehot_d = '0;
               valid_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         onehot_q <= '0;
         index_q  <= '0;
         valid_q  <= 1'b0;
`ifdef ONEHOT_SEQ_SCAN_EN
         steps_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         onehot_q <= onehot_d;
         index_q  <= index_d;
         valid_q  <= valid_d;
`ifdef ONEHOT_SEQ_SCAN_EN
         steps_q  <= steps_d;
`endif
      end
   end

   assign out_onehot = onehot_q;
   assign out_index  = index_q;
   assign out_valid  = valid_q;

endmodule
`default_nettype wire
